// File: rtl/side_road_detector_pkg.sv
// rtl/side_road_detector_pkg.sv - shared light encodings and sensor defaults
// Shared with the highway/normal-road light controller.
//   light_e              : one-hot normal-road light code {red,green,yellow}
//   DEBOUNCE_CYC_DEFAULT : stable synchronized cycles before a loop level is accepted
//   MAX_QUEUE_DEFAULT    : queue count saturation value
package side_road_detector_pkg;

  typedef enum logic [2:0] {
    RED    = 3'b100,
    GREEN  = 3'b010,
    YELLOW = 3'b001
  } light_e;

  localparam int DEBOUNCE_CYC_DEFAULT = 4;
  localparam int MAX_QUEUE_DEFAULT    = 15;

endpackage

// File: rtl/side_road_detector_loop_debounce.sv
// rtl/side_road_detector_loop_debounce.sv - 2-flop synchronizer plus debouncer for one inductive loop
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high; clears sync flops, counter and level
//   raw    : asynchronous loop input, 1 = vehicle over loop
//   level  : accepted (debounced) loop level
//   rise   : high in the cycle whose closing edge flips level 0->1
//   fall   : high in the cycle whose closing edge flips level 1->0
// rise/fall are combinational so the consumer can act on the same edge that
// updates level.
module loop_debounce
  import side_road_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The synchronized value has differed from level long enough.
  assign accept = (s2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
  assign rise   = accept && s2;
  assign fall   = accept && !s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        // Any return to the accepted level discards a partial run.
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/side_road_detector.sv
// rtl/side_road_detector.sv - side-road car-present detector with vehicle queue count
// Optional feature macro: RED_RUN_DETECT_EN (red-light-run flag).
// Ports:
//   clock       : system clock, rising edge
//   reset       : synchronous, active-high
//   arrive_raw  : raw upstream loop (asynchronous)
//   exit_raw    : raw stop-line loop (asynchronous)
//   normal      : controller's normal-road light, one-hot {red,green,yellow}
//   in          : registered car-present request, high while queue non-empty
//   queue_count : registered saturating count of waiting vehicles
//   underflow   : sticky, exit seen with an empty queue
//   red_run     : sticky, exit seen while light not green (0 unless RED_RUN_DETECT_EN)
module side_road_detector
  import side_road_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int MAX_QUEUE    = MAX_QUEUE_DEFAULT,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arrive_raw,
  input  logic             exit_raw,
  input  logic [2:0]       normal,
  output logic             in,
  output logic [CNT_W-1:0] queue_count,
  output logic             underflow,
  output logic             red_run
);

  logic             arr_level, arr_rise, arr_fall;
  logic             ex_level, ex_rise, ex_fall;
  logic [CNT_W-1:0] next_count;
  logic             next_under;

  loop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arrive (
    .clock (clock),
    .reset (reset),
    .raw   (arrive_raw),
    .level (arr_level),
    .rise  (arr_rise),
    .fall  (arr_fall)
  );

  // A vehicle leaves the queue when it clears the stop line (falling level).
  loop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_exit (
    .clock (clock),
    .reset (reset),
    .raw   (exit_raw),
    .level (ex_level),
    .rise  (ex_rise),
    .fall  (ex_fall)
  );

  always_comb begin
    next_count = queue_count;
    next_under = underflow;
    case ({arr_rise, ex_fall})
      2'b10: begin
        if (queue_count != CNT_W'(MAX_QUEUE)) next_count = queue_count + CNT_W'(1);
      end
      2'b01: begin
        if (queue_count != '0) next_count = queue_count - CNT_W'(1);
        else                   next_under = 1'b1;
      end
      default: ; // none, or simultaneous arrival and exit: count holds
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      queue_count <= '0;
      underflow   <= 1'b0;
      in          <= 1'b0;
    end else begin
      queue_count <= next_count;
      underflow   <= next_under;
      in          <= (next_count != '0);
    end
  end

`ifdef RED_RUN_DETECT_EN
  // Any non-one-hot light code is treated as not green.
  always_ff @(posedge clock) begin
    if (reset) red_run <= 1'b0;
    else if (ex_fall && (normal != GREEN)) red_run <= 1'b1;
  end

  logic unused_levels;
  assign unused_levels = ^{arr_level, arr_fall, ex_level, ex_rise};
`else
  assign red_run = 1'b0;

  // normal is kept on the port list for interface stability only.
  logic unused_levels;
  assign unused_levels = ^{arr_level, arr_fall, ex_level, ex_rise, normal};
`endif

endmodule

// File: tb/tb_side_road_detector.sv
// tb/tb_side_road_detector.sv - scoreboard bench for side_road_detector
module tb_side_road_detector;
  import side_road_detector_pkg::*;

  localparam int D    = 4;
  localparam int MAXQ = 15;
  localparam int CW   = 4;
  localparam int NE   = 8192;

  logic          clock = 1'b0;
  logic          reset;
  logic          arrive_raw;
  logic          exit_raw;
  logic [2:0]    normal;
  logic          in;
  logic [CW-1:0] queue_count;
  logic          underflow;
  logic          red_run;

  side_road_detector #(.DEBOUNCE_CYC(D), .MAX_QUEUE(MAXQ), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .arrive_raw  (arrive_raw),
    .exit_raw    (exit_raw),
    .normal      (normal),
    .in          (in),
    .queue_count (queue_count),
    .underflow   (underflow),
    .red_run     (red_run)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   n;
    logic in_v;
    int   cnt;
    logic und;
    logic red;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: full input history indexed by edge number.
  bit rawh [2][NE];
  bit rsth [NE];
  int m_n = 0;
  bit m_lvl [2];
  int m_mark [2];
  int m_cnt = 0;
  bit m_und = 1'b0;
  bit m_red = 1'b0;

  // Value the debouncer sees at edge k: the raw sample from two edges
  // earlier, or 0 if a reset cleared the synchronizer in between.
  function automatic bit obs(input int p, input int k);
    if (k < 2) return 1'b0;
    if (rsth[k-1] || rsth[k-2]) return 1'b0;
    return rawh[p][k-2];
  endfunction

  task automatic check(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, n, got, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("in",          x.n, 32'(in),          32'(x.in_v));
      check("queue_count", x.n, 32'(queue_count), 32'(x.cnt));
      check("underflow",   x.n, 32'(underflow),   32'(x.und));
      check("red_run",     x.n, 32'(red_run),     32'(x.red));
    end
  end

  task automatic step(input bit a, input bit e, input logic [2:0] nrm, input bit r);
    exp_t x;
    bit   ev [2];
    bit   acc;
    arrive_raw = a;
    exit_raw   = e;
    normal     = nrm;
    reset      = r;
    rawh[0][m_n] = a;
    rawh[1][m_n] = e;
    rsth[m_n]    = r;
    if (r) begin
      m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
      m_mark[0] = m_n; m_mark[1] = m_n;
      m_cnt = 0; m_und = 1'b0; m_red = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        // Accept once the last D observations since the last reset or
        // acceptance all disagree with the accepted level.
        acc = (m_n - m_mark[p] >= D);
        for (int j = 0; j < D; j++)
          if (obs(p, m_n - j) == m_lvl[p]) acc = 1'b0;
        ev[p] = 1'b0;
        if (acc) begin
          m_lvl[p]  = !m_lvl[p];
          m_mark[p] = m_n;
          ev[p]     = (p == 0) ? m_lvl[p] : !m_lvl[p];
        end
      end
      if (ev[0] && !ev[1]) m_cnt = (m_cnt < MAXQ) ? m_cnt + 1 : MAXQ;
      if (ev[1] && !ev[0]) begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else           m_und = 1'b1;
      end
`ifdef RED_RUN_DETECT_EN
      if (ev[1] && nrm != GREEN) m_red = 1'b1;
`endif
    end
    x.n = m_n; x.in_v = (m_cnt != 0); x.cnt = m_cnt; x.und = m_und; x.red = m_red;
    m_n++;
    @(posedge clock);
    #1;
    sb.push_back(x);
  endtask

  task automatic hold(input bit a, input bit e, input logic [2:0] nrm, input int cyc);
    for (int i = 0; i < cyc; i++) step(a, e, nrm, 1'b0);
  endtask

  task automatic arrival();
    hold(1'b1, 1'b0, GREEN, 6);
    hold(1'b0, 1'b0, GREEN, 6);
  endtask

  task automatic departure(input logic [2:0] nrm);
    hold(1'b0, 1'b1, nrm, 6);
    hold(1'b0, 1'b0, nrm, 6);
  endtask

  // Arrival level rises and exit level falls on the same edge.
  task automatic simultaneous();
    hold(1'b0, 1'b1, GREEN, 6);
    hold(1'b1, 1'b0, GREEN, 6);
    hold(1'b0, 1'b0, GREEN, 6);
  endtask

  initial begin
    int ha, he;
    bit ra, re;
    logic [2:0] nr;

    // Reset then idle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, GREEN, 1'b1);
    hold(1'b0, 1'b0, GREEN, 5);

    // Reset mid-debounce, then a stable 1 needs the full latency again.
    hold(1'b1, 1'b0, GREEN, 4);
    step(1'b1, 1'b0, GREEN, 1'b1);
    hold(1'b1, 1'b0, GREEN, 8);
    hold(1'b0, 1'b0, GREEN, 8);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, GREEN, 1'b1);

    // Short glitch rejected, long pulse accepted.
    hold(1'b1, 1'b0, GREEN, 3);
    hold(1'b0, 1'b0, GREEN, 8);
    hold(1'b1, 1'b0, GREEN, 10);
    hold(1'b0, 1'b0, GREEN, 8);

    // Saturation at MAX_QUEUE, then drain on green.
    for (int i = 0; i < 16; i++) arrival();
    for (int i = 0; i < 15; i++) departure(GREEN);

    // Exit on empty queue: sticky underflow.
    departure(GREEN);
    hold(1'b0, 1'b0, GREEN, 10);
    step(1'b0, 1'b0, GREEN, 1'b1);

    // Simultaneous events at 0 and at MAX_QUEUE.
    simultaneous();
    for (int i = 0; i < 15; i++) arrival();
    simultaneous();
    step(1'b0, 1'b0, GREEN, 1'b1);

    // Exit on red with two queued.
    arrival();
    arrival();
    departure(RED);
    departure(3'b011);
    step(1'b0, 1'b0, GREEN, 1'b1);

    // Randomized traffic, light codes and occasional resets.
    ha = 0; he = 0; ra = 1'b0; re = 1'b0; nr = GREEN;
    for (int i = 0; i < 2500; i++) begin
      if (ha == 0) begin ra = 1'($urandom_range(0, 1)); ha = $urandom_range(1, 9); end
      if (he == 0) begin re = 1'($urandom_range(0, 1)); he = $urandom_range(1, 11); end
      ha--; he--;
      if ($urandom_range(0, 15) == 0) nr = 3'($urandom);
      step(ra, re, nr, ($urandom_range(0, 399) == 0));
    end
    hold(1'b0, 1'b0, GREEN, 2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/side_road_detector.md
Name: side_road_detector

Overview:
- Sensor front-end that produces the `in` car-present request consumed by the highway/normal-road light controller.
- Synchronizes and debounces two raw inductive-loop inputs: an upstream arrival loop and a stop-line exit loop.
- Maintains a saturating count of queued vehicles on the normal road and asserts `in` while the queue is non-empty.
- Watches the controller's `normal` light output to flag exits with an empty queue and, optionally, red-light runs.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable cycles required before a synchronized loop level is accepted (>=1)
MAX_QUEUE, 15, queue count saturation value
CNT_W, 4, width of queue_count; must satisfy 2**CNT_W > MAX_QUEUE

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
arrive_raw  input  1  raw upstream loop, asynchronous, 1 = vehicle over loop
exit_raw  input  1  raw stop-line loop, asynchronous, 1 = vehicle over loop
normal  input  3  controller's normal-road light {red,green,yellow}, one-hot: 100 red, 010 green, 001 yellow
in  output  1  car-present request to controller, registered
queue_count  output  CNT_W  vehicles waiting, registered
underflow  output  1  sticky: exit seen while queue_count == 0
red_run  output  1  sticky: exit seen while normal != green (RED_RUN_DETECT_EN only; else tied 0)

Behaviour:
- Reset (synchronous, highest priority, any cycle including mid-debounce):
  - All outputs go to 0.
  - Sync flops, debounce counters and accepted levels are cleared to 0.
- Each loop path runs through a 2-flop synchronizer, then a debouncer.
- Debouncer, per clock edge:
  - s2 == level: cnt <= 0.
  - s2 != level and cnt == DEBOUNCE_CYC-1: level <= s2, cnt <= 0.
  - s2 != level otherwise: cnt <= cnt+1.
- Arrival event:
  - Fires on the edge where the arrival path's level flips 0->1.
- Exit event:
  - Fires on the edge where the exit path's level flips 1->0 (vehicle has cleared the stop line).
- Falling arrival edges and rising exit edges have no effect.
- Latency:
  - A raw level stable from edge k is accepted at edge k+1+DEBOUNCE_CYC.
  - queue_count and `in` update on that same edge (next-state computed from the event).
  - For DEBOUNCE_CYC=4, a raw rise first sampled at edge 1 gives in=1 at edge 6.
- Glitch rejection:
  - A raw pulse stable for fewer than DEBOUNCE_CYC synchronized cycles is discarded; cnt is reset on mismatch loss.
- Queue update:
  - Arrival only: +1, saturating at MAX_QUEUE (no wrap).
  - Exit only: -1 if count > 0; if count == 0, count stays 0 and underflow <= 1.
  - Arrival and exit in the same cycle: count unchanged, even at 0 or MAX_QUEUE; no underflow.
- `in` <= (next queue_count != 0).
- `normal` is used only for red_run. Any non-one-hot code counts as not green.
- Sticky flags clear only on reset.

Optional Feature:
- Macro RED_RUN_DETECT_EN.
- Defined:
  - An exit event with normal != 3'b010 sets red_run <= 1 (sticky).
  - The queue update still occurs.
- Undefined:
  - red_run is a constant 0.
  - No logic reads `normal`; the port remains for interface stability.

Decomposition:
- Shared package (also used by the light controller) holds:
  - Light encodings RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
  - Default DEBOUNCE_CYC and MAX_QUEUE constants.
- One sub-module, loop_debounce:
  - Contents: 2-flop sync, counter, accepted level, one-cycle rise/fall event outputs; parameter DEBOUNCE_CYC.
  - Instantiated twice.
- Top level holds the queue counter, flags and `in`.

Test Plan:
- Reset then idle: all outputs 0; assert reset mid-debounce (cnt=2) -> after release, a stable 1 still needs full 2+DEBOUNCE_CYC edges.
- arrive_raw high 3 cycles (DEBOUNCE_CYC=4) -> no event, queue_count=0, in=0; high 10 cycles -> queue_count=1, in=1 exactly at edge 6 after first sample.
- 16 debounced arrivals, MAX_QUEUE=15 -> queue_count saturates at 15; 15 exits with normal=010 -> queue_count=0, in drops on the 15th exit edge, underflow=0, red_run=0.
- Exit with queue_count=0 -> queue_count stays 0, underflow=1 and remains 1 until reset.
- Arrival and exit levels flipping on the same edge at count=0 and at count=15 -> count unchanged, underflow=0.
- RED_RUN_DETECT_EN defined, count=2, normal=100, one exit -> queue_count=1, red_run=1; same with macro undefined -> red_run=0.
